// File: rtl/turret_bullet_ctrl.sv
// Single-bullet projectile controller: launches from the turret muzzle on a fire edge,
// steps once per frame tick, retires on edge exit or hit, then holds off for a cooldown.
module turret_bullet_ctrl #(
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int STEP_SHIFT = 1,
  parameter int COOLDOWN   = 8
) (
  input  logic       clk2,
  input  logic       Reset,
  input  logic       fire,
  input  logic [9:0] motion_x_in,
  input  logic [9:0] motion_y_in,
  input  logic [9:0] origin_x,
  input  logic [9:0] origin_y,
  input  logic       hit,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [7:0] shot_count
);

  // state  | meaning
  // S_IDLE | no bullet, waiting for a fire edge with non-zero aim
  // S_FLY  | bullet in flight, stepping once per tick
  // S_COOL | bullet retired, counting down before the next launch is allowed
  typedef enum logic [1:0] {S_IDLE, S_FLY, S_COOL} state_e;

  localparam int COOL_TICKS = (COOLDOWN < 1) ? 1 : COOLDOWN;
  localparam int CW         = (COOL_TICKS < 2) ? 1 : $clog2(COOL_TICKS);
  localparam logic [CW-1:0]     COOL_LOAD = CW'(COOL_TICKS - 1);
  localparam logic signed [11:0] X_LIM    = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM    = 12'(Y_MAX);

  state_e        state_q, state_d;
  logic [9:0]    bullet_x_q, bullet_x_d;
  logic [9:0]    bullet_y_q, bullet_y_d;
  logic [9:0]    vx_q, vx_d;
  logic [9:0]    vy_q, vy_d;
  logic [CW-1:0] cool_cnt_q, cool_cnt_d;
  logic [7:0]    shot_count_q, shot_count_d;
  logic          fire_prev_q;

  logic              fire_rise;
  logic              aim_nonzero;
  logic signed [11:0] vx_ext, vy_ext;
  logic signed [11:0] step_x, step_y;
  logic signed [11:0] nx, ny;
  logic               out_of_bounds;

  assign fire_rise   = fire & ~fire_prev_q;
  assign aim_nonzero = (motion_x_in != 10'd0) || (motion_y_in != 10'd0);

  // 12-bit signed math leaves headroom so an exit past either edge is visible, never wrapped
  assign vx_ext = {{2{vx_q[9]}}, vx_q};
  assign vy_ext = {{2{vy_q[9]}}, vy_q};
  assign step_x = vx_ext <<< STEP_SHIFT;
  assign step_y = vy_ext <<< STEP_SHIFT;
  assign nx     = $signed({2'b00, bullet_x_q}) + step_x;
  assign ny     = $signed({2'b00, bullet_y_q}) + step_y;

  assign out_of_bounds = nx[11] || (nx > X_LIM) || ny[11] || (ny > Y_LIM);

  always_comb begin
    state_d      = state_q;
    bullet_x_d   = bullet_x_q;
    bullet_y_d   = bullet_y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    cool_cnt_d   = cool_cnt_q;
    shot_count_d = shot_count_q;

    case (state_q)
      S_IDLE: begin
        if (fire_rise && aim_nonzero) begin
          state_d      = S_FLY;
          bullet_x_d   = origin_x;
          bullet_y_d   = origin_y;
          vx_d         = motion_x_in;
          vy_d         = motion_y_in;
          shot_count_d = shot_count_q + 8'd1;
        end
      end
      S_FLY: begin
        if (hit || out_of_bounds) begin
          state_d    = S_COOL;
          cool_cnt_d = COOL_LOAD;
        end else begin
          bullet_x_d = nx[9:0];
          bullet_y_d = ny[9:0];
        end
      end
      S_COOL: begin
        if (cool_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      bullet_x_q   <= '0;
      bullet_y_q   <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      cool_cnt_q   <= '0;
      shot_count_q <= '0;
      fire_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bullet_x_q   <= bullet_x_d;
      bullet_y_q   <= bullet_y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      cool_cnt_q   <= cool_cnt_d;
      shot_count_q <= shot_count_d;
      fire_prev_q  <= fire;
    end
  end

  assign bullet_active = (state_q == S_FLY);
  assign bullet_x      = bullet_x_q;
  assign bullet_y      = bullet_y_q;
  assign shot_count    = shot_count_q;

endmodule
